// File: rtl/processador_pkg.sv
// Shared types and constants for the processador accumulator core.
// Build option PROCESSADOR_SHIFT_EN is consumed in processador_alu.
package processador_pkg;

    localparam int DATA_W = 8;
    localparam int OPC_W  = 4;

    typedef enum logic [OPC_W-1:0] {
        OPC_NOP  = 4'h0,
        OPC_ADD  = 4'h1,
        OPC_SUB  = 4'h2,
        OPC_ADC  = 4'h3,
        OPC_SBB  = 4'h4,
        OPC_AND  = 4'h5,
        OPC_OR   = 4'h6,
        OPC_XOR  = 4'h7,
        OPC_NOT  = 4'h8,
        OPC_LDI  = 4'h9,
        OPC_LDH  = 4'hA,
        OPC_CMP  = 4'hB,
        OPC_SHL  = 4'hC,
        OPC_SHR  = 4'hD,
        OPC_RSVE = 4'hE,
        OPC_RSVF = 4'hF
    } opcode_t;

    typedef struct packed {
        logic z;
        logic c;
        logic v;
    } flags_t;

    // Signed overflow of a+b giving r.
    function automatic logic add_ovf(input logic a7, input logic b7, input logic r7);
        return (~a7 & ~b7 & r7) | (a7 & b7 & ~r7);
    endfunction

    // Signed overflow of a-b giving r.
    function automatic logic sub_ovf(input logic a7, input logic b7, input logic r7);
        return (a7 ^ b7) & (a7 ^ r7);
    endfunction

endpackage

// File: rtl/processador_alu.sv
// Combinational ALU: computes the new accumulator value and flags plus write enables.
// Shifts (0xC/0xD) exist only when PROCESSADOR_SHIFT_EN is defined.
module processador_alu
    import processador_pkg::*;
(
    input  opcode_t             opcode,
    input  logic [DATA_W-1:0]   a,
    input  logic [DATA_W-1:0]   b,
    input  logic                cin,
    output logic [DATA_W-1:0]   r,
    output logic                acc_we,
    output flags_t              flags,
    output logic                flags_we
);

    logic [DATA_W-1:0] and_v;
    logic [DATA_W-1:0] or_v;
    logic [DATA_W-1:0] xor_v;
    logic [DATA_W-1:0] not_v;

    genvar gi;
    generate
        for (gi = 0; gi < DATA_W; gi++) begin : g_logic
            assign and_v[gi] = a[gi] & b[gi];
            assign or_v[gi]  = a[gi] | b[gi];
            assign xor_v[gi] = a[gi] ^ b[gi];
            assign not_v[gi] = ~a[gi];
        end
    endgenerate

    // Carry-in only participates for ADC/SBB; the 9th bit is carry or borrow.
    logic              use_cin;
    logic [DATA_W:0]   sum9;
    logic [DATA_W:0]   diff9;

    assign use_cin = (opcode == OPC_ADC) || (opcode == OPC_SBB);
    assign sum9    = {1'b0, a} + {1'b0, b} + {{DATA_W{1'b0}}, use_cin & cin};
    assign diff9   = {1'b0, a} - {1'b0, b} - {{DATA_W{1'b0}}, use_cin & cin};

    always_comb begin
        r        = a;
        acc_we   = 1'b0;
        flags_we = 1'b0;
        flags    = '0;
        unique case (opcode)
            OPC_ADD, OPC_ADC: begin
                r        = sum9[DATA_W-1:0];
                acc_we   = 1'b1;
                flags_we = 1'b1;
                flags.c  = sum9[DATA_W];
                flags.v  = add_ovf(a[DATA_W-1], b[DATA_W-1], sum9[DATA_W-1]);
            end
            OPC_SUB, OPC_SBB, OPC_CMP: begin
                r        = diff9[DATA_W-1:0];
                acc_we   = (opcode != OPC_CMP);
                flags_we = 1'b1;
                flags.c  = diff9[DATA_W];
                flags.v  = sub_ovf(a[DATA_W-1], b[DATA_W-1], diff9[DATA_W-1]);
            end
            OPC_AND: begin
                r        = and_v;
                acc_we   = 1'b1;
                flags_we = 1'b1;
            end
            OPC_OR: begin
                r        = or_v;
                acc_we   = 1'b1;
                flags_we = 1'b1;
            end
            OPC_XOR: begin
                r        = xor_v;
                acc_we   = 1'b1;
                flags_we = 1'b1;
            end
            OPC_NOT: begin
                r        = not_v;
                acc_we   = 1'b1;
                flags_we = 1'b1;
            end
            OPC_LDI: begin
                r        = b;
                acc_we   = 1'b1;
                flags_we = 1'b1;
            end
            OPC_LDH: begin
                r        = {b[3:0], a[3:0]};
                acc_we   = 1'b1;
                flags_we = 1'b1;
            end
`ifdef PROCESSADOR_SHIFT_EN
            OPC_SHL: begin
                r        = {a[DATA_W-2:0], 1'b0};
                acc_we   = 1'b1;
                flags_we = 1'b1;
                flags.c  = a[DATA_W-1];
                flags.v  = a[DATA_W-1] ^ a[DATA_W-2];
            end
            OPC_SHR: begin
                r        = {1'b0, a[DATA_W-1:1]};
                acc_we   = 1'b1;
                flags_we = 1'b1;
                flags.c  = a[0];
            end
`endif
            default: begin
                r        = a;
                acc_we   = 1'b0;
                flags_we = 1'b0;
            end
        endcase
        // Zero always reflects the computed value, including CMP where ACC is kept.
        flags.z = (r == '0);
    end

endmodule

// File: rtl/processador.sv
// Single-cycle 8-bit accumulator core: instruction decode plus ACC/flag registers.
// Shift opcodes are enabled by defining PROCESSADOR_SHIFT_EN.
module processador
    import processador_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic [DATA_W-1:0]   instr,
    output logic [DATA_W-1:0]   result,
    output logic                zero_flag,
    output logic                carry_flag,
    output logic                overflow_flag
);

    opcode_t             opcode;
    logic [DATA_W-1:0]   imm_ext;

    assign opcode  = opcode_t'(instr[DATA_W-1:DATA_W-OPC_W]);
    assign imm_ext = {{(DATA_W-OPC_W){1'b0}}, instr[OPC_W-1:0]};

    logic [DATA_W-1:0]   acc_reg;
    flags_t              flags_reg;
    logic [DATA_W-1:0]   acc_next;
    flags_t              flags_next;

    logic [DATA_W-1:0]   alu_r;
    logic                alu_acc_we;
    flags_t              alu_flags;
    logic                alu_flags_we;

    processador_alu u_alu (
        .opcode   (opcode),
        .a        (acc_reg),
        .b        (imm_ext),
        .cin      (flags_reg.c),
        .r        (alu_r),
        .acc_we   (alu_acc_we),
        .flags    (alu_flags),
        .flags_we (alu_flags_we)
    );

    always_comb begin
        acc_next   = alu_acc_we   ? alu_r     : acc_reg;
        flags_next = alu_flags_we ? alu_flags : flags_reg;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_reg   <= '0;
            flags_reg <= '0;
        end else begin
            acc_reg   <= acc_next;
            flags_reg <= flags_next;
        end
    end

    assign result        = acc_reg;
    assign zero_flag     = flags_reg.z;
    assign carry_flag    = flags_reg.c;
    assign overflow_flag = flags_reg.v;

endmodule

// File: tb/tb_processador.sv
// Directed self-checking bench for processador; one line per executed instruction.
`timescale 1ns/1ps
module tb_processador;

    logic       clk;
    logic       rst_n;
    logic [7:0] instr;
    logic [7:0] result;
    logic       zero_flag;
    logic       carry_flag;
    logic       overflow_flag;

    int n_checks;
    int n_errors;

    processador dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .instr         (instr),
        .result        (result),
        .zero_flag     (zero_flag),
        .carry_flag    (carry_flag),
        .overflow_flag (overflow_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", tag, obs, exp_v);
        end
    endtask

    // Check all four outputs against expected values.
    task automatic chk_all(input string tag, input logic [7:0] r, input logic z,
                           input logic c, input logic v);
        chk({tag, ".res"}, result, r);
        chk({tag, ".z"},   {7'b0, zero_flag},     {7'b0, z});
        chk({tag, ".c"},   {7'b0, carry_flag},    {7'b0, c});
        chk({tag, ".v"},   {7'b0, overflow_flag}, {7'b0, v});
    endtask

    task automatic step(input logic [7:0] i);
        instr = i;
        @(posedge clk);
        #1;
        $display("instr=0x%02h -> result=0x%02h Z=%0b C=%0b V=%0b",
                 i, result, zero_flag, carry_flag, overflow_flag);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        instr    = 8'h00;
        rst_n    = 1'b0;
        #12;
        chk_all("reset", 8'h00, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic add/sub sequence
        step(8'h10); chk_all("add0", 8'h00, 1'b1, 1'b0, 1'b0);
        step(8'h11); chk_all("add1", 8'h01, 1'b0, 1'b0, 1'b0);
        step(8'h20); chk_all("sub0", 8'h01, 1'b0, 1'b0, 1'b0);
        step(8'h21); chk_all("sub1", 8'h00, 1'b1, 1'b0, 1'b0);

        // Signed overflow 0x7F + 1
        step(8'h9F); chk("ldi_f", result, 8'h0F);
        step(8'hA7); chk("ldh_7", result, 8'h7F);
        step(8'h11); chk_all("ovf_add", 8'h80, 1'b0, 1'b0, 1'b1);

        // Unsigned carry 0xFF + 1, then NOP holds, then ADC consumes carry
        step(8'h9F);
        step(8'hAF); chk("ldh_f", result, 8'hFF);
        step(8'h11); chk_all("carry_add", 8'h00, 1'b1, 1'b1, 1'b0);
        step(8'h00); chk_all("nop_hold", 8'h00, 1'b1, 1'b1, 1'b0);
        step(8'h32); chk_all("adc", 8'h03, 1'b0, 1'b0, 1'b0);

        // Borrow chain
        step(8'h90);
        step(8'h21); chk_all("borrow_sub", 8'hFF, 1'b0, 1'b1, 1'b0);
        step(8'h40); chk_all("sbb", 8'hFE, 1'b0, 1'b0, 1'b0);

        // Signed overflow 0x80 - 1
        step(8'h90);
        step(8'hA8); chk("ldh_8", result, 8'h80);
        step(8'h21); chk_all("ovf_sub", 8'h7F, 1'b0, 1'b0, 1'b1);

        // CMP and logic
        step(8'h95);
        step(8'hB5); chk_all("cmp_eq", 8'h05, 1'b1, 1'b0, 1'b0);
        step(8'h75); chk_all("xor", 8'h00, 1'b1, 1'b0, 1'b0);
        step(8'h80); chk_all("not", 8'hFF, 1'b0, 1'b0, 1'b0);
        step(8'h53); chk_all("and", 8'h03, 1'b0, 1'b0, 1'b0);
        step(8'h6C); chk_all("or", 8'h0F, 1'b0, 1'b0, 1'b0);
        step(8'hB9); chk_all("cmp_gt", 8'h0F, 1'b0, 1'b0, 1'b0);

        // Shift region: 0x8C, CMP F sets V and leaves ACC
        step(8'h9C);
        step(8'hA8); chk("ldh_8c", result, 8'h8C);
        step(8'hBF); chk_all("cmp_v", 8'h8C, 1'b0, 1'b0, 1'b1);
`ifdef PROCESSADOR_SHIFT_EN
        step(8'hC0); chk_all("shl", 8'h18, 1'b0, 1'b1, 1'b1);
        step(8'hD0); chk_all("shr", 8'h0C, 1'b0, 1'b0, 1'b0);
        // Prepare ACC=0x55 with C=1 via SHR of 0xAB
        step(8'h9B);
        step(8'hAA);
        step(8'hD0); chk_all("pre_rst", 8'h55, 1'b0, 1'b1, 1'b0);
`else
        step(8'hC0); chk_all("shl_rsv", 8'h8C, 1'b0, 1'b0, 1'b1);
        step(8'hD0); chk_all("shr_rsv", 8'h8C, 1'b0, 1'b0, 1'b1);
        step(8'h95);
        step(8'hA5); chk("pre_rst", result, 8'h55);
`endif
        step(8'hE3); chk("rsv_e", result, 8'h55);
        step(8'hF7); chk("rsv_f", result, 8'h55);

        // Asynchronous reset mid-cycle, well before the next rising edge
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("async_rst", 8'h00, 1'b0, 1'b0, 1'b0);
        instr = 8'h11;
        @(posedge clk);
        #1;
        chk_all("rst_held", 8'h00, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step(8'hE3); chk_all("post_rsv", 8'h00, 1'b0, 1'b0, 1'b0);
        step(8'h11); chk_all("post_add", 8'h01, 1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
